// File: rtl/even_sweep_ctrl.sv
// Sweep sequencer for a 4-bit even up/down counter: clear, then run
// 0 -> HI_LIMIT -> 0 a fixed number of times with optional turnaround dwell.
module even_sweep_ctrl #(
    parameter int HI_LIMIT = 14,
    parameter int SWEEPS   = 2,
    parameter int DWELL    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] cnt_q,
    output logic       cnt_clr,
    output logic       cnt_en,
    output logic       cnt_y,
    output logic       busy,
    output logic       done,
    output logic [3:0] sweep_cnt,
    output logic       err
);

    localparam logic [3:0] HI = 4'(HI_LIMIT);
    localparam logic [3:0] SW = 4'(SWEEPS);
    localparam logic [3:0] DW = 4'(DWELL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_UP,
        S_TURN_HI,
        S_DOWN,
        S_TURN_LO,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] sweep_q, sweep_d;
    logic [3:0] dwell_q, dwell_d;
    logic       err_q, err_d;

    logic       q_bad;
    logic       at_top;
    logic       at_bot;
    logic [3:0] sweep_inc;

    // An odd value or one above the top can never come from a healthy counter.
    assign q_bad     = cnt_q[0] | (cnt_q > HI);
    assign at_top    = (cnt_q == HI);
    assign at_bot    = (cnt_q == 4'd0);
    assign sweep_inc = sweep_q + 4'd1;

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        dwell_d = dwell_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_CLEAR;
                    sweep_d = 4'd0;
                    err_d   = 1'b0;
                end
            end
            S_CLEAR: begin
                state_d = abort ? S_IDLE : S_UP;
            end
            S_UP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (q_bad) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (at_top) begin
                    state_d = S_TURN_HI;
                    dwell_d = DW;
                end
            end
            S_TURN_HI: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (dwell_q == 4'd0) begin
                    state_d = S_DOWN;
                end else begin
                    dwell_d = dwell_q - 4'd1;
                end
            end
            S_DOWN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (q_bad) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (at_bot) begin
                    sweep_d = sweep_inc;
                    if (sweep_inc == SW) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_TURN_LO;
                        dwell_d = DW;
                    end
                end
            end
            S_TURN_LO: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (dwell_q == 4'd0) begin
                    state_d = S_UP;
                end else begin
                    dwell_d = dwell_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sweep_q <= 4'd0;
            dwell_q <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            dwell_q <= dwell_d;
            err_q   <= err_d;
        end
    end

    // Stepping is suppressed in the abort cycle so the counter freezes.
    always_comb begin
        cnt_clr   = (state_q == S_CLEAR);
        cnt_y     = (state_q == S_DOWN) || (state_q == S_TURN_LO);
        cnt_en    = !abort &&
                    (((state_q == S_UP) && !at_top) ||
                     ((state_q == S_DOWN) && !at_bot));
        busy      = (state_q != S_IDLE) && (state_q != S_DONE);
        done      = (state_q == S_DONE);
        sweep_cnt = sweep_q;
        err       = err_q;
    end

endmodule
